// File: rtl/tts_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM states,
// table depth and the packed result record.
package tts_pkg;

  localparam int TTS_N_IN = 4;
  localparam int TT_DEPTH = 2 ** TTS_N_IN;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } tts_state_e;

  typedef struct packed {
    logic                pass;
    logic [TTS_N_IN:0]   err_count;
    logic [TTS_N_IN-1:0] first_fail;
    logic [TT_DEPTH-1:0] fail_map;
  } tts_result_t;

  // Compares are only accepted while vectors are issued or still in flight.
  function automatic logic in_sweep(tts_state_e s);
    return (s == ISSUE) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/tts_delay_line.sv
// Aligns an issued {valid, idx} word with the cell response that arrives
// LAT cycles later; LAT=0 is a plain wire for a combinational cell.
module tts_delay_line #(
  parameter int LAT = 0,
  parameter int W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] payload,
  output logic [W-1:0] delayed
);

  generate
    if (LAT == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign delayed        = payload;
    end else begin : g_chain
      logic [W-1:0] stage [LAT];

      always_ff @(posedge clk) begin
        // NOTE: every stage is reset, not just the head; a stale valid bit
        // left in the chain would retire a bogus compare after reset.
        if (!rst_n) begin
          for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
          stage[0] <= payload;
          for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
      end

      assign delayed = stage[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 2**N_IN input vectors of a single-output logic cell, compares
// each response to a latched golden table and reports a result summary.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int N_IN = TTS_N_IN,
  parameter int LAT  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      vec_out,
  output logic                 vec_valid,
  input  logic                 dut_e,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      first_fail,
  output logic [2**N_IN-1:0]   fail_map
);

  localparam logic [N_IN-1:0] LAST_IDX = '1;

  tts_state_e           state;
  logic [N_IN-1:0]      idx_q;
  logic [2**N_IN-1:0]   expected_q;
  tts_result_t          res_q;

  logic [N_IN:0]        dl_word;
  logic                 dl_valid;
  logic [N_IN-1:0]      dl_idx;

  logic                 mismatch;
  logic                 last_retire;
  logic [TTS_N_IN:0]    err_next;

  tts_delay_line #(
    .LAT (LAT),
    .W   (N_IN + 1)
  ) u_delay_line (
    .clk     (clk),
    .rst_n   (rst_n),
    .payload ({vec_valid, vec_out}),
    .delayed (dl_word)
  );

  assign dl_valid = dl_word[N_IN];
  assign dl_idx   = dl_word[N_IN-1:0];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the ifs can leave a value held, which would infer a latch.
    mismatch    = 1'b0;
    last_retire = 1'b0;
    if (in_sweep(state) && dl_valid) begin
      mismatch    = (dut_e != expected_q[dl_idx]);
      last_retire = (state == DRAIN) && (dl_idx == LAST_IDX);
    end
    err_next = res_q.err_count + {{TTS_N_IN{1'b0}}, mismatch};
  end

  always_ff @(posedge clk) begin
    // NOTE: all state here uses <= so every register samples the values
    // from before this edge, regardless of statement order.
    if (!rst_n) begin
      state      <= IDLE;
      idx_q      <= '0;
      expected_q <= '0;
      vec_out    <= '0;
      vec_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      res_q      <= '0;
    end else begin
      done <= 1'b0;

      unique case (state)
        IDLE, DONE: begin
          // DONE with done low is the HOLD sub-state; start restarts from here.
          if (start) begin
            state      <= ISSUE;
            idx_q      <= '0;
            expected_q <= expected;
            res_q      <= '0;
          end
        end
        ISSUE: begin
          vec_out   <= idx_q;
          vec_valid <= 1'b1;
          busy      <= 1'b1;
          idx_q     <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) state <= DRAIN;
        end
        DRAIN: begin
          vec_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (mismatch) begin
        res_q.fail_map[dl_idx] <= 1'b1;
        res_q.err_count        <= err_next;
        if (res_q.err_count == '0) res_q.first_fail <= dl_idx;
      end

      // Results are final at the edge that retires the last vector.
      if (last_retire) begin
        state      <= DONE;
        done       <= 1'b1;
        busy       <= 1'b0;
        res_q.pass <= (err_next == '0);
      end
    end
  end

  assign pass       = res_q.pass;
  assign err_count  = res_q.err_count;
  assign first_fail = res_q.first_fail;
  assign fail_map   = res_q.fail_map;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: two sweepers (combinational cell, 2-cycle registered
// cell) share stimulus; expected results come from table arithmetic.
module tb_truth_table_sweeper;

  typedef struct {
    int          acc;
    int          done_at;
    logic [15:0] map;
    logic [4:0]  err;
    logic [3:0]  ff;
    logic        pass;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0;
  logic        start2 = 1'b0;
  logic [15:0] expected = '0;
  logic [15:0] cell_tt = '0;

  logic [3:0]  vec_out0, vec_out2, ff0, ff2;
  logic        vec_valid0, vec_valid2, busy0, busy2, done0, done2, pass0, pass2;
  logic [4:0]  err0, err2;
  logic [15:0] map0, map2;
  logic        dut_e0, dut_e2, cell_r1;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  exp_t q0[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Cell under evaluation: combinational for u_dut0, two registers for u_dut2.
  assign dut_e0 = cell_tt[vec_out0];
  always @(posedge clk) begin
    cell_r1 <= cell_tt[vec_out2];
    dut_e2  <= cell_r1;
  end

  truth_table_sweeper #(.N_IN(4), .LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .expected(expected),
    .vec_out(vec_out0), .vec_valid(vec_valid0), .dut_e(dut_e0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail(ff0), .fail_map(map0)
  );

  truth_table_sweeper #(.N_IN(4), .LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .expected(expected),
    .vec_out(vec_out2), .vec_valid(vec_valid2), .dut_e(dut_e2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail(ff2), .fail_map(map2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  // Full-sweep reference: the fail map is simply where golden and cell differ.
  function automatic exp_t model(input logic [15:0] e, input logic [15:0] c,
                                 input int acc, input int lat);
    exp_t m;
    m.map  = e ^ c;
    m.err  = '0;
    m.ff   = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m.map[i]) begin
        m.err = m.err + 5'd1;
        m.ff  = 4'(i);
      end
    end
    m.pass    = (m.err == 0);
    m.acc     = acc;
    m.done_at = acc + 17 + lat;
    return m;
  endfunction

  task automatic monitor_inst(input int which, input logic done_s, input logic busy_s,
                              input logic vv_s, input logic [3:0] vo_s, input logic pass_s,
                              input logic [4:0] err_s, input logic [3:0] ff_s,
                              input logic [15:0] map_s);
    exp_t  e;
    bit    have;
    bit    exp_busy, exp_vv, exp_done;
    string p;
    p    = (which == 0) ? "lat0" : "lat2";
    have = (which == 0) ? (q0.size() != 0) : (q2.size() != 0);
    exp_busy = 1'b0;
    exp_vv   = 1'b0;
    exp_done = 1'b0;
    if (have) begin
      if (which == 0) e = q0[0];
      else            e = q2[0];
      exp_busy = (edge_cnt > e.acc) && (edge_cnt < e.done_at);
      exp_vv   = (edge_cnt > e.acc) && (edge_cnt <= e.acc + 16);
      exp_done = (edge_cnt == e.done_at);
    end
    check({p, "_busy"}, 32'(busy_s), 32'(exp_busy));
    check({p, "_vec_valid"}, 32'(vv_s), 32'(exp_vv));
    if (exp_vv) check({p, "_vec_out"}, 32'(vo_s), 32'(edge_cnt - e.acc - 1));
    check({p, "_done"}, 32'(done_s), 32'(exp_done));
    if (exp_done) begin
      check({p, "_pass"}, 32'(pass_s), 32'(e.pass));
      check({p, "_err_count"}, 32'(err_s), 32'(e.err));
      check({p, "_first_fail"}, 32'(ff_s), 32'(e.ff));
      check({p, "_fail_map"}, 32'(map_s), 32'(e.map));
      if (which == 0) void'(q0.pop_front());
      else            void'(q2.pop_front());
    end
  endtask

  always @(negedge clk) begin
    monitor_inst(0, done0, busy0, vec_valid0, vec_out0, pass0, err0, ff0, map0);
    monitor_inst(1, done2, busy2, vec_valid2, vec_out2, pass2, err2, ff2, map2);
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lat0_outs"}, 32'({vec_out0, vec_valid0, busy0, done0, pass0, err0, ff0}), 32'd0);
    check({tag, "_lat0_map"}, 32'(map0), 32'd0);
    check({tag, "_lat2_outs"}, 32'({vec_out2, vec_valid2, busy2, done2, pass2, err2, ff2}), 32'd0);
    check({tag, "_lat2_map"}, 32'(map2), 32'd0);
  endtask

  // Called 1 time unit after an edge; returns 1 time unit after the accepting edge.
  task automatic launch(input bit s0, input bit s2, input logic [15:0] e);
    expected = e;
    start0   = s0;
    start2   = s2;
    @(posedge clk); #1;
    start0 = 1'b0;
    start2 = 1'b0;
    if (s0) q0.push_back(model(e, cell_tt, edge_cnt, 0));
    if (s2) q2.push_back(model(e, cell_tt, edge_cnt, 2));
  endtask

  task automatic wait_edge(input int target);
    while (edge_cnt < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 200 && (q0.size() + q2.size()) != 0; i++) begin
      @(posedge clk); #1;
    end
    check("sweep_completion", 32'(q0.size() + q2.size()), 32'd0);
    q0.delete();
    q2.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    int          a;
    logic [15:0] e1;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Correct a&b&d cell against its own table.
    cell_tt = 16'hA000;
    launch(1, 1, 16'hA000);
    wait_quiet();

    // Cell stuck at 0 and stuck at 1.
    cell_tt = 16'h0000;
    launch(1, 1, 16'hA000);
    wait_quiet();
    cell_tt = 16'hFFFF;
    launch(1, 1, 16'h0000);
    wait_quiet();

    // start re-pulses and expected changes mid-sweep are ignored.
    cell_tt = 16'($urandom);
    e1      = 16'($urandom);
    launch(1, 1, e1);
    a = edge_cnt;
    wait_edge(a + 3);
    expected = ~e1;
    wait_edge(a + 5);
    start0 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start2 = 1'b0;
    wait_edge(a + 10);
    start0 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start2 = 1'b0;
    wait_quiet();

    // Reset in the middle of a sweep, then a fresh sweep.
    cell_tt = 16'h1234;
    launch(1, 1, 16'h4321);
    a = edge_cnt;
    wait_edge(a + 8);
    rst_n = 1'b0;
    @(posedge clk); #1;
    q0.delete();
    q2.delete();
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    launch(1, 1, 16'h4321);
    wait_quiet();

    // Back-to-back: start held during each instance's done cycle.
    cell_tt = 16'hFFFF;
    launch(1, 1, 16'h0000);
    a = edge_cnt;
    wait_edge(a + 17);
    expected = 16'h00FF;
    start0   = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    q0.push_back(model(16'h00FF, cell_tt, edge_cnt, 0));
    check("b2b_lat0_err_cleared", 32'(err0), 32'd0);
    check("b2b_lat0_map_cleared", 32'(map0), 32'd0);
    wait_edge(a + 19);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    q2.push_back(model(16'h00FF, cell_tt, edge_cnt, 2));
    check("b2b_lat2_err_cleared", 32'(err2), 32'd0);
    wait_quiet();

    // Randomized sweeps: exact match, single-bit error, or unrelated table.
    for (int n = 0; n < 24; n++) begin
      int mode;
      cell_tt = 16'($urandom);
      mode    = int'($urandom_range(0, 2));
      if (mode == 0)      e1 = cell_tt;
      else if (mode == 1) e1 = cell_tt ^ (16'h1 << $urandom_range(0, 15));
      else                e1 = 16'($urandom);
      launch(1, 1, e1);
      repeat ($urandom_range(1, 12)) @(posedge clk);
      #1;
      expected = 16'($urandom);
      wait_quiet();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
